// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared definitions for the RAM arbiter.
//   arb_state_e : arbiter FSM states (ARB_IDLE, ARB_BUS)
//   ARB_PORTS   : number of requester ports
//   ARB_CU      : port index of the control unit
//   ARB_AUX     : port index of the auxiliary requester (loader / debug / DMA)
package ram_arb_pkg;

    localparam int ARB_PORTS = 2;
    localparam int ARB_CU    = 0;
    localparam int ARB_AUX   = 1;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUS  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/ram_arb_sel.sv
// ram_arb_sel: combinational two-way winner selection.
//   eligible [1:0] in  : ports that may be granted this cycle
//   last           in  : port granted most recently
//   winner         out : selected port index (meaningful only when valid)
//   valid          out : at least one port is eligible
// Build option: RAM_ARB_FIXED_PRIO_EN gives port 0 absolute priority on a tie;
// otherwise a tie goes to the port that was not granted last.
module ram_arb_sel
    import ram_arb_pkg::*;
(
    input  logic [ARB_PORTS-1:0] eligible,
    input  logic                 last,
    output logic                 winner,
    output logic                 valid
);

    always_comb begin
        valid  = |eligible;
        winner = 1'b0;
`ifdef RAM_ARB_FIXED_PRIO_EN
        // Port 0 whenever it is eligible; port 1 only when alone.
        winner = ~eligible[ARB_CU];
`else
        if (&eligible) begin
            winner = ~last;
        end else begin
            winner = ~eligible[ARB_CU];
        end
`endif
    end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-ported RAM between two requesters.
// One access at a time: the grant cycle registers address and strobe, the next
// cycle captures read data and pulses the owner's ack.
//   clk, rst_n                     : clock, asynchronous active-low reset
//   req0/1, we0/1, addr0/1, wdata0/1 : request side, held until ack
//   ack0/1, rdata0/1               : one-cycle ack, read data held after ack
//   addressbus, read, write, toram : RAM command side (address/data hold)
//   fromram                        : RAM read data, valid while read strobe high
// Build option: RAM_ARB_FIXED_PRIO_EN (see ram_arb_sel).
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int adlines   = 8,
    parameter int datalines = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0,
    input  logic                 req1,
    input  logic                 we0,
    input  logic                 we1,
    input  logic [adlines-1:0]   addr0,
    input  logic [adlines-1:0]   addr1,
    input  logic [datalines-1:0] wdata0,
    input  logic [datalines-1:0] wdata1,
    output logic                 ack0,
    output logic                 ack1,
    output logic [datalines-1:0] rdata0,
    output logic [datalines-1:0] rdata1,
    output logic [adlines-1:0]   addressbus,
    output logic                 read,
    output logic                 write,
    output logic [datalines-1:0] toram,
    input  logic [datalines-1:0] fromram
);

    arb_state_e             state_q, state_d;
    logic                   last_q, last_d;
    logic                   owner_q, owner_d;
    logic [adlines-1:0]     addressbus_q, addressbus_d;
    logic                   read_q, read_d;
    logic                   write_q, write_d;
    logic [datalines-1:0]   toram_q, toram_d;
    logic [ARB_PORTS-1:0]   ack_q, ack_d;
    logic [datalines-1:0]   rdata0_q, rdata0_d;
    logic [datalines-1:0]   rdata1_q, rdata1_d;

    logic [ARB_PORTS-1:0]   req_vec;
    logic [ARB_PORTS-1:0]   eligible;
    logic                   grant;
    logic                   grant_valid;

    logic                   sel_we;
    logic [adlines-1:0]     sel_addr;
    logic [datalines-1:0]   sel_wdata;

    assign req_vec = {req1, req0};

    // A port in its ack cycle is masked so a still-held request is not re-granted.
    for (genvar gi = 0; gi < ARB_PORTS; gi++) begin : g_elig
        assign eligible[gi] = req_vec[gi] & ~ack_q[gi];
    end

    ram_arb_sel u_sel (
        .eligible (eligible),
        .last     (last_q),
        .winner   (grant),
        .valid    (grant_valid)
    );

    assign sel_we    = grant ? we1    : we0;
    assign sel_addr  = grant ? addr1  : addr0;
    assign sel_wdata = grant ? wdata1 : wdata0;

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        owner_d      = owner_q;
        addressbus_d = addressbus_q;
        read_d       = 1'b0;
        write_d      = 1'b0;
        toram_d      = toram_q;
        ack_d        = '0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;

        case (state_q)
            ARB_IDLE: begin
                if (grant_valid) begin
                    state_d      = ARB_BUS;
                    last_d       = grant;
                    owner_d      = grant;
                    addressbus_d = sel_addr;
                    read_d       = ~sel_we;
                    write_d      = sel_we;
                    if (sel_we) begin
                        toram_d = sel_wdata;
                    end
                end
            end
            ARB_BUS: begin
                // read_q still reflects the access being completed.
                state_d        = ARB_IDLE;
                ack_d[owner_q] = 1'b1;
                if (read_q) begin
                    if (owner_q) begin
                        rdata1_d = fromram;
                    end else begin
                        rdata0_d = fromram;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            last_q       <= 1'b1;      // port 0 wins the first tie
            owner_q      <= 1'b0;
            addressbus_q <= '0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            toram_q      <= '0;
            ack_q        <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            owner_q      <= owner_d;
            addressbus_q <= addressbus_d;
            read_q       <= read_d;
            write_q      <= write_d;
            toram_q      <= toram_d;
            ack_q        <= ack_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    assign ack0       = ack_q[ARB_CU];
    assign ack1       = ack_q[ARB_AUX];
    assign rdata0     = rdata0_q;
    assign rdata1     = rdata1_q;
    assign addressbus = addressbus_q;
    assign read       = read_q;
    assign write      = write_q;
    assign toram      = toram_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed and random stimulus for ram_arbiter, checked every
// cycle against a transaction-level reference model (one access in flight,
// round-robin pick, reference memory updated at grant time).
module tb_ram_arbiter;

    localparam int AW = 8;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]    breq;
    logic [1:0]    bwe;
    logic [AW-1:0] baddr  [2];
    logic [DW-1:0] bwdata [2];

    logic          ack0, ack1, read, write;
    logic [DW-1:0] rdata0, rdata1, toram, fromram;
    logic [AW-1:0] addressbus;

    ram_arbiter #(.adlines(AW), .datalines(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0       (breq[0]),
        .req1       (breq[1]),
        .we0        (bwe[0]),
        .we1        (bwe[1]),
        .addr0      (baddr[0]),
        .addr1      (baddr[1]),
        .wdata0     (bwdata[0]),
        .wdata1     (bwdata[1]),
        .ack0       (ack0),
        .ack1       (ack1),
        .rdata0     (rdata0),
        .rdata1     (rdata1),
        .addressbus (addressbus),
        .read       (read),
        .write      (write),
        .toram      (toram),
        .fromram    (fromram)
    );

    // RAM environment: asynchronous read, synchronous write, preload port.
    logic [DW-1:0] ram [256];
    logic          ld_en = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_data = '0;
    assign fromram = ram[addressbus];
    always @(posedge clk) begin
        if (ld_en) ram[ld_addr] <= ld_data;
        else if (write) ram[addressbus] <= toram;
    end

    // Reference model state.
    logic [DW-1:0] ref_mem [256];
    logic [AW-1:0] e_addressbus;
    logic          e_read, e_write;
    logic [DW-1:0] e_toram;
    logic [1:0]    e_ack;
    logic [DW-1:0] e_rdata [2];
    int            inflight;
    bit            inf_we;
    int            inf_addr;
    int            last_g;

    int    checks = 0;
    int    errors = 0;
    string phase = "reset";
    int    cnt_ack [2];
    bit    held [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        e_addressbus = '0; e_read = 1'b0; e_write = 1'b0; e_toram = '0;
        e_ack = '0; e_rdata[0] = '0; e_rdata[1] = '0;
        inflight = -1; inf_we = 1'b0; inf_addr = 0; last_g = 1;
    endtask

    // Advance the model by one clock using the current request inputs.
    task automatic predict();
        logic [1:0] ack_now;
        logic [1:0] el;
        int w;
        ack_now = e_ack;
        e_ack = '0; e_read = 1'b0; e_write = 1'b0;
        if (inflight >= 0) begin
            e_ack[inflight] = 1'b1;
            if (!inf_we) e_rdata[inflight] = ref_mem[inf_addr];
            inflight = -1;
        end else begin
            el[0] = breq[0] & ~ack_now[0];
            el[1] = breq[1] & ~ack_now[1];
            if (el != 2'b00) begin
                if (el == 2'b11) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
                    w = 0;
`else
                    w = (last_g == 0) ? 1 : 0;
`endif
                end else begin
                    w = el[0] ? 0 : 1;
                end
                last_g = w;
                e_addressbus = baddr[w];
                e_read  = ~bwe[w];
                e_write = bwe[w];
                if (bwe[w]) begin
                    e_toram = bwdata[w];
                    ref_mem[baddr[w]] = bwdata[w];
                end
                inflight = w;
                inf_we   = bwe[w];
                inf_addr = int'(baddr[w]);
            end
        end
    endtask

    task automatic check_outputs();
        chk({phase, ".addressbus"}, 32'(addressbus), 32'(e_addressbus));
        chk({phase, ".read"},       32'(read),       32'(e_read));
        chk({phase, ".write"},      32'(write),      32'(e_write));
        chk({phase, ".toram"},      32'(toram),      32'(e_toram));
        chk({phase, ".ack0"},       32'(ack0),       32'(e_ack[0]));
        chk({phase, ".ack1"},       32'(ack1),       32'(e_ack[1]));
        chk({phase, ".rdata0"},     32'(rdata0),     32'(e_rdata[0]));
        chk({phase, ".rdata1"},     32'(rdata1),     32'(e_rdata[1]));
    endtask

    task automatic tick();
        if (rst_n) predict();
        @(posedge clk);
        #1;
        if (!rst_n) model_reset();
        check_outputs();
        cnt_ack[0] += int'(ack0);
        cnt_ack[1] += int'(ack1);
        $display("cycle %-12s req=%b we=%b ab=%02h rd=%b wr=%b to=%04h ack=%b%b rd0=%04h rd1=%04h",
                 phase, breq, bwe, addressbus, read, write, toram, ack1, ack0, rdata0, rdata1);
    endtask

    task automatic set_port(input int p, input logic r, input logic we,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        breq[p] = r; bwe[p] = we; baddr[p] = a; bwdata[p] = d;
    endtask

    task automatic rand_fields(input int p);
        bwe[p]    = 1'($urandom_range(1, 0));
        baddr[p]  = AW'($urandom_range(15, 0));
        bwdata[p] = DW'($urandom);
    endtask

    initial begin
        breq = '0; bwe = '0;
        baddr[0] = '0; baddr[1] = '0; bwdata[0] = '0; bwdata[1] = '0;
        cnt_ack[0] = 0; cnt_ack[1] = 0; held[0] = 0; held[1] = 0;
        model_reset();

        // Preload RAM and reference memory while reset is held.
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            ld_en = 1'b1; ld_addr = AW'(i);
            ld_data = (i == 8'h12) ? 16'hBEEF : DW'($urandom);
            ref_mem[i] = ld_data;
        end
        @(negedge clk);
        ld_en = 1'b0;

        // Reset state.
        @(posedge clk); #1;
        phase = "reset";
        check_outputs();
        rst_n = 1'b1;

        // Idle: no requests for 5 cycles.
        phase = "idle";
        for (int i = 0; i < 5; i++) tick();

        // Single read on port 0.
        phase = "read0";
        set_port(0, 1'b1, 1'b0, 8'h12, 16'h0000);
        tick();
        chk("read0.strobe", 32'(read), 32'd1);
        chk("read0.addr", 32'(addressbus), 32'h12);
        tick();
        chk("read0.ack", 32'(ack0), 32'd1);
        chk("read0.data", 32'(rdata0), 32'hBEEF);
        breq[0] = 1'b0;
        tick();
        chk("read0.single_ack", 32'(ack0), 32'd0);

        // Single write on port 1, then read-back on port 0.
        phase = "write1";
        set_port(1, 1'b1, 1'b1, 8'h05, 16'h1234);
        tick();
        chk("write1.strobe", 32'(write), 32'd1);
        chk("write1.toram", 32'(toram), 32'h1234);
        chk("write1.addr", 32'(addressbus), 32'h05);
        tick();
        chk("write1.ack", 32'(ack1), 32'd1);
        breq[1] = 1'b0;
        phase = "readback";
        set_port(0, 1'b1, 1'b0, 8'h05, 16'h0000);
        tick();
        tick();
        chk("readback.data", 32'(rdata0), 32'h1234);
        breq[0] = 1'b0;
        tick();

        // Contention: both ports held for 8 cycles.
        phase = "contend";
        set_port(0, 1'b1, 1'b0, 8'h03, 16'h0000);
        set_port(1, 1'b1, 1'b0, 8'h04, 16'h0000);
        cnt_ack[0] = 0; cnt_ack[1] = 0;
        for (int i = 0; i < 8; i++) tick();
        breq = '0;
`ifndef RAM_ARB_FIXED_PRIO_EN
        chk("contend.ack0_count", 32'(cnt_ack[0]), 32'd2);
        chk("contend.ack1_count", 32'(cnt_ack[1]), 32'd2);
`endif
        tick();
        tick();

        // Reset during the BUS cycle of a read.
        phase = "midreset";
        set_port(0, 1'b1, 1'b0, 8'h12, 16'h0000);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        breq[0] = 1'b0;
        tick();
        rst_n = 1'b1;
        phase = "reissue";
        breq[0] = 1'b1;
        tick();
        chk("reissue.strobe", 32'(read), 32'd1);
        tick();
        chk("reissue.ack", 32'(ack0), 32'd1);
        chk("reissue.data", 32'(rdata0), 32'hBEEF);
        breq[0] = 1'b0;
        tick();

        // Random traffic from both ports.
        phase = "random";
        for (int n = 0; n < 300; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (e_ack[p]) begin
                    if ($urandom_range(1, 0) == 1) begin
                        breq[p] = 1'b0; held[p] = 0;
                    end else begin
                        held[p] = 1;
                    end
                end else if (held[p]) begin
                    held[p] = 0;
                    rand_fields(p);
                end else if (!breq[p] && $urandom_range(9, 0) < 5) begin
                    breq[p] = 1'b1;
                    rand_fields(p);
                end
            end
            tick();
        end
        breq = '0;
        phase = "drain";
        for (int i = 0; i < 4; i++) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
